// File: rtl/ghost_move_commit_pkg.sv
// Shared constants, FSM state type and tile-index helper for the ghost move-commit slice.
// Playfield is 640x480 pixels split into a 32x24 grid of 20-pixel tiles.
package ghost_move_commit_pkg;

  localparam int WIDTH        = 640;
  localparam int HEIGHT       = 480;
  localparam int TILE_ROW_NUM = 24;
  localparam int TILE_COL_NUM = 32;

  localparam int XW       = $clog2(WIDTH);
  localparam int YW       = $clog2(HEIGHT);
  localparam int QW       = $clog2((TILE_COL_NUM > TILE_ROW_NUM) ? TILE_COL_NUM : TILE_ROW_NUM);
  localparam int MAP_BITS = TILE_ROW_NUM * TILE_COL_NUM;
  localparam int IDX_W    = $clog2(MAP_BITS);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_DIVIDE,
    ST_CHECK,
    ST_COMMIT
  } state_t;

  // Wall map is row-major: bit = row * columns + col.
  function automatic logic [IDX_W-1:0] tile_index(input logic [QW-1:0] row,
                                                  input logic [QW-1:0] col);
    return IDX_W'(row) * IDX_W'(TILE_COL_NUM) + IDX_W'(col);
  endfunction

endpackage

// File: rtl/ghost_move_commit_tile_div.sv
// tile_div_step: iterative divide-by-TILE, one subtract per cycle after start.
// done is high whenever the remainder has dropped below TILE; quotient is then the floor.
module tile_div_step
  import ghost_move_commit_pkg::*;
#(
  parameter int W    = 10,
  parameter int Q_W  = QW,
  parameter int TILE = 20
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   value,
  output logic           done,
  output logic [Q_W-1:0] quotient
);

  localparam logic [W-1:0] TILE_L = W'(TILE);

  logic [W-1:0]   rem_q, rem_d;
  logic [Q_W-1:0] quot_q, quot_d;

  always_comb begin
    rem_d  = rem_q;
    quot_d = quot_q;
    if (start) begin
      rem_d  = value;
      quot_d = '0;
    end else if (rem_q >= TILE_L) begin
      rem_d  = rem_q - TILE_L;
      quot_d = quot_q + Q_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      quot_q <= '0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
    end
  end

  assign done     = (rem_q < TILE_L);
  assign quotient = quot_q;

endmodule

// File: rtl/ghost_move_commit.sv
// ghost_move_commit: latches a proposed ghost step, finds its tile, checks walls and commits or holds.
// Define GHOST_TUNNEL_EN to wrap horizontally out-of-bounds targets to the opposite edge.
module ghost_move_commit
  import ghost_move_commit_pkg::*;
#(
  parameter int unsigned START_X   = 260,
  parameter int unsigned START_Y   = 240,
  parameter logic [1:0]  START_DIR = DIR_LEFT,
  parameter int unsigned TILE      = 20,
  parameter int unsigned BOUND_X1  = 620,
  parameter int unsigned BOUND_Y1  = 460
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                move_tick,
  input  logic [XW-1:0]       next_x,
  input  logic [YW-1:0]       next_y,
  input  logic [1:0]          dir_in,
  input  logic [MAP_BITS-1:0] tilemap_walls,
  input  logic [XW-1:0]       pac_x,
  input  logic [YW-1:0]       pac_y,
  output logic [XW-1:0]       x,
  output logic [YW-1:0]       y,
  output logic [1:0]          dir_out,
  output logic                busy,
  output logic                step_done,
  output logic                blocked,
  output logic                collide,
  output logic                overrun
);

  localparam logic [XW-1:0] BX1 = XW'(BOUND_X1);
  localparam logic [YW-1:0] BY1 = YW'(BOUND_Y1);

  state_t state_q, state_d;

  logic [XW-1:0] tgt_x_q, tgt_x_d;
  logic [YW-1:0] tgt_y_q, tgt_y_d;
  logic [1:0]    tgt_dir_q, tgt_dir_d;
  logic          oob_q, oob_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [1:0]    dir_q, dir_d;
  logic          busy_q, busy_d;
  logic          step_done_q, step_done_d;
  logic          blocked_q, blocked_d;
  logic          collide_q, collide_d;
  logic          overrun_q, overrun_d;

  logic          x_oob, y_oob;
  logic          div_start;
  logic          div_x_done, div_y_done;
  logic [QW-1:0] col_quot, row_quot;
  logic          wall;

  tile_div_step #(.W(XW), .Q_W(QW), .TILE(TILE)) u_div_x (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .value    (tgt_x_d),
    .done     (div_x_done),
    .quotient (col_quot)
  );

  tile_div_step #(.W(YW), .Q_W(QW), .TILE(TILE)) u_div_y (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .value    (tgt_y_d),
    .done     (div_y_done),
    .quotient (row_quot)
  );

  assign wall = tilemap_walls[tile_index(row_quot, col_quot)];

  always_comb begin
    state_d     = state_q;
    tgt_x_d     = tgt_x_q;
    tgt_y_d     = tgt_y_q;
    tgt_dir_d   = tgt_dir_q;
    oob_d       = oob_q;
    x_d         = x_q;
    y_d         = y_q;
    dir_d       = dir_q;
    step_done_d = 1'b0;
    blocked_d   = blocked_q;
    div_start   = 1'b0;
    x_oob       = 1'b0;
    y_oob       = 1'b0;
    overrun_d   = overrun_q | (move_tick && (state_q != ST_IDLE));
    collide_d   = (x_q == pac_x) && (y_q == pac_y);

    case (state_q)
      ST_IDLE: begin
        if (move_tick) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        tgt_x_d   = next_x;
        tgt_y_d   = next_y;
        tgt_dir_d = dir_in;
        x_oob     = (next_x > BX1);
        y_oob     = (next_y > BY1);
`ifdef GHOST_TUNNEL_EN
        if (x_oob && (dir_in == DIR_LEFT)) begin
          tgt_x_d = BX1;
          x_oob   = 1'b0;
        end else if (x_oob && (dir_in == DIR_RIGHT)) begin
          tgt_x_d = '0;
          x_oob   = 1'b0;
        end
`endif
        oob_d = x_oob | y_oob;
        // An out-of-range target is rejected outright, so the divide is skipped.
        if (x_oob | y_oob) begin
          state_d = ST_CHECK;
        end else begin
          div_start = 1'b1;
          state_d   = ST_DIVIDE;
        end
      end
      ST_DIVIDE: begin
        if (div_x_done && div_y_done) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        blocked_d   = oob_q | wall;
        step_done_d = 1'b1;
        if (!(oob_q | wall)) begin
          x_d   = tgt_x_q;
          y_d   = tgt_y_q;
          dir_d = tgt_dir_q;
        end
        state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tgt_x_q     <= '0;
      tgt_y_q     <= '0;
      tgt_dir_q   <= '0;
      oob_q       <= 1'b0;
      x_q         <= XW'(START_X);
      y_q         <= YW'(START_Y);
      dir_q       <= START_DIR;
      busy_q      <= 1'b0;
      step_done_q <= 1'b0;
      blocked_q   <= 1'b0;
      collide_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_x_q     <= tgt_x_d;
      tgt_y_q     <= tgt_y_d;
      tgt_dir_q   <= tgt_dir_d;
      oob_q       <= oob_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_q       <= dir_d;
      busy_q      <= busy_d;
      step_done_q <= step_done_d;
      blocked_q   <= blocked_d;
      collide_q   <= collide_d;
      overrun_q   <= overrun_d;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign dir_out   = dir_q;
  assign busy      = busy_q;
  assign step_done = step_done_q;
  assign blocked   = blocked_q;
  assign collide   = collide_q;
  assign overrun   = overrun_q;

endmodule
